// File: rtl/fetch_decode.sv
// Program counter, instruction fetch over req/ack, decode into control fields, and JCTL branch resolution.
// Three or more cycles per instruction; stalls in FETCH until imem_ack, and in EXEC while exec_busy is high.
module fetch_decode #(
  parameter int PC_WIDTH = 8
) (
  input  logic                CLK,
  input  logic                RST,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [23:0]         imem_data,
  input  logic                exec_busy,
  input  logic                alu_zero,
  output logic [3:0]          a_addr,
  output logic [3:0]          b_addr,
  output logic [3:0]          c_addr,
  output logic [7:0]          immediate_val,
  output logic [7:0]          addr,
  output logic [2:0]          alu_control,
  output logic [1:0]          JCTL,
  output logic                im_sel,
  output logic                reg_write,
  output logic                data_read,
  output logic                data_write,
  output logic                reg_addr,
  output logic                issue_valid,
  output logic                halted,
  output logic [PC_WIDTH-1:0] pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [PC_WIDTH-1:0] r_pc;
  logic [3:0]          r_op;
  logic [3:0]          r_a;
  logic [3:0]          r_b;
  logic [3:0]          r_c;
  logic [7:0]          r_imm;
  logic [2:0]          r_alu;
  logic [1:0]          r_jctl;
  logic                r_im_sel;
  logic                r_reg_write;
  logic                r_data_read;
  logic                r_data_write;
  logic                r_reg_addr;

  logic [2:0]          w_alu;
  logic [1:0]          w_jctl;
  logic                w_im_sel;
  logic                w_reg_write;
  logic                w_data_read;
  logic                w_data_write;
  logic                w_reg_addr;
  logic                w_take;
  logic [PC_WIDTH-1:0] w_pc_next;

  // Opcode to control-field map; anything not set for an opcode stays 0.
  always_comb begin
    w_alu        = 3'b000;
    w_jctl       = 2'b00;
    w_im_sel     = 1'b0;
    w_reg_write  = 1'b0;
    w_data_read  = 1'b0;
    w_data_write = 1'b0;
    w_reg_addr   = 1'b0;
    case (imem_data[23:20])
      4'h1: begin w_alu = 3'b000; w_reg_write = 1'b1; end
      4'h2: begin w_alu = 3'b001; w_reg_write = 1'b1; end
      4'h3: begin w_alu = 3'b010; w_reg_write = 1'b1; end
      4'h4: begin w_alu = 3'b011; w_reg_write = 1'b1; end
      4'h5: begin w_alu = 3'b100; w_reg_write = 1'b1; end
      4'h6: begin w_alu = 3'b000; w_im_sel = 1'b1; w_reg_write = 1'b1; end
      4'h7: begin w_alu = 3'b101; w_im_sel = 1'b1; w_reg_write = 1'b1; end
      4'h8: begin w_data_read = 1'b1; w_reg_write = 1'b1; end
      4'h9: w_data_write = 1'b1;
      4'hA: begin w_data_read = 1'b1; w_reg_write = 1'b1; w_reg_addr = 1'b1; end
      4'hB: begin w_data_write = 1'b1; w_reg_addr = 1'b1; end
      4'hC: w_jctl = 2'b01;
      4'hD: w_jctl = 2'b10;
      4'hE: w_jctl = 2'b11;
      default: ;
    endcase
  end

  always_comb begin
    case (r_jctl)
      2'b01:   w_take = 1'b1;
      2'b10:   w_take = alu_zero;
      2'b11:   w_take = ~alu_zero;
      default: w_take = 1'b0;
    endcase
    w_pc_next = w_take ? r_imm[PC_WIDTH-1:0]
                       : r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    imem_req    = 1'b0;
    issue_valid = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) w_next = S_DECODE;
      end
      S_DECODE: begin
        issue_valid = 1'b1;
        w_next      = (r_op == 4'hF) ? S_HALT : S_EXEC;
      end
      S_EXEC:   if (!exec_busy) w_next = S_FETCH;
      S_HALT:   halted = 1'b1;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc         <= '0;
      r_op         <= 4'h0;
      r_a          <= 4'h0;
      r_b          <= 4'h0;
      r_c          <= 4'h0;
      r_imm        <= 8'h00;
      r_alu        <= 3'b000;
      r_jctl       <= 2'b00;
      r_im_sel     <= 1'b0;
      r_reg_write  <= 1'b0;
      r_data_read  <= 1'b0;
      r_data_write <= 1'b0;
      r_reg_addr   <= 1'b0;
    end else begin
      if (r_state == S_FETCH && imem_ack) begin
        r_op         <= imem_data[23:20];
        r_c          <= imem_data[19:16];
        r_a          <= imem_data[15:12];
        r_b          <= imem_data[11:8];
        r_imm        <= imem_data[7:0];
        r_alu        <= w_alu;
        r_jctl       <= w_jctl;
        r_im_sel     <= w_im_sel;
        r_reg_write  <= w_reg_write;
        r_data_read  <= w_data_read;
        r_data_write <= w_data_write;
        r_reg_addr   <= w_reg_addr;
      end
      if (r_state == S_EXEC && !exec_busy) r_pc <= w_pc_next;
    end
  end

  // immediate_val and addr are the same field, viewed as data or as a target.
  assign imem_addr     = r_pc;
  assign pc            = r_pc;
  assign a_addr        = r_a;
  assign b_addr        = r_b;
  assign c_addr        = r_c;
  assign immediate_val = r_imm;
  assign addr          = r_imm;
  assign alu_control   = r_alu;
  assign JCTL          = r_jctl;
  assign im_sel        = r_im_sel;
  assign reg_write     = r_reg_write;
  assign data_read     = r_data_read;
  assign data_write    = r_data_write;
  assign reg_addr      = r_reg_addr;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: reset, ack stall, memory stall, branches, wrap, halt, reset mid-operation.
module tb_fetch_decode;

  logic        CLK;
  logic        RST;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [23:0] imem_data;
  logic        exec_busy;
  logic        alu_zero;
  logic [3:0]  a_addr, b_addr, c_addr;
  logic [7:0]  immediate_val, addr;
  logic [2:0]  alu_control;
  logic [1:0]  JCTL;
  logic        im_sel, reg_write, data_read, data_write, reg_addr;
  logic        issue_valid, halted;
  logic [7:0]  pc;

  logic [23:0] mem [256];
  int          n_vec;
  int          n_err;
  int          cnt;

  assign imem_data = mem[imem_addr];

  fetch_decode #(.PC_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .exec_busy(exec_busy), .alu_zero(alu_zero),
    .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
    .immediate_val(immediate_val), .addr(addr), .alu_control(alu_control), .JCTL(JCTL),
    .im_sel(im_sel), .reg_write(reg_write), .data_read(data_read), .data_write(data_write),
    .reg_addr(reg_addr), .issue_valid(issue_valid), .halted(halted), .pc(pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 24'h000000;
    mem[8'h01] = 24'h1A2355;  // ADD c=A a=2 b=3
    mem[8'h02] = 24'hA12007;  // LDR
    mem[8'h03] = 24'hD00040;  // JZ 0x40 (taken)
    mem[8'h40] = 24'hD00040;  // same JZ (not taken)
    mem[8'h41] = 24'hE00010;  // JNZ 0x10
    mem[8'h10] = 24'hC000FF;  // JMP 0xFF
    mem[8'hFF] = 24'h000000;  // NOP, wraps to 0
    RST = 1'b1; imem_ack = 1'b1; exec_busy = 1'b0; alu_zero = 1'b0;

    cyc(); cyc();
    check("rst_pc", 32'(pc), 0);
    check("rst_req", 32'(imem_req), 0);
    check("rst_flags", 32'({issue_valid, halted}), 0);
    check("rst_fields", 32'({a_addr, b_addr, c_addr, immediate_val, addr}), 0);
    check("rst_ctrl", 32'({alu_control, JCTL, im_sel, reg_write, data_read, data_write, reg_addr}), 0);
    RST = 1'b0;
    check("idle_req", 32'(imem_req), 0);
    cyc();
    check("first_req", 32'(imem_req), 1);
    check("first_addr", 32'(imem_addr), 0);
    cyc();
    check("nop_iv", 32'(issue_valid), 1);
    cyc();
    check("nop_exec_iv", 32'(issue_valid), 0);
    cyc();
    check("fetch1_addr", 32'(imem_addr), 1);
    mem[8'h00] = 24'hF12345;  // HALT for the pass after wrap

    // ADD with ack delayed three cycles
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (imem_req) cnt++;
      imem_ack = (k == 3);
      cyc();
    end
    check("ack_req_cycles", 32'(cnt), 4);
    check("add_iv", 32'(issue_valid), 1);
    check("add_regs", 32'({c_addr, a_addr, b_addr}), 32'h0A23);
    check("add_imm", 32'(immediate_val), 32'h55);
    check("add_ctrl", 32'({alu_control, JCTL, im_sel, reg_write, data_read, data_write, reg_addr}),
          32'b000_00_0_1_0_0_0);
    cyc(); cyc();
    check("fetch2_addr", 32'(imem_addr), 2);

    // LDR with four busy cycles in EXEC
    exec_busy = 1'b1;
    cyc();
    check("ldr_ctrl", 32'({alu_control, JCTL, im_sel, reg_write, data_read, data_write, reg_addr}),
          32'b000_00_0_1_1_0_1);
    cyc();
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (pc == 8'h02 && !imem_req) cnt++;
      if (k == 4) exec_busy = 1'b0;
      cyc();
    end
    check("stall_hold", 32'(cnt), 5);
    check("stall_pc_inc", 32'(pc), 3);
    check("stall_req", 32'(imem_req), 1);

    // JZ taken, JZ not taken, JNZ taken, JMP to 0xFF, wrap
    alu_zero = 1'b1;
    cyc();
    check("jz_jctl", 32'(JCTL), 2);
    cyc(); cyc();
    check("jz_taken", 32'(imem_addr), 32'h40);
    alu_zero = 1'b0;
    cyc(); cyc(); cyc();
    check("jz_not_taken", 32'(imem_addr), 32'h41);
    cyc();
    check("jnz_jctl", 32'(JCTL), 3);
    cyc(); cyc();
    check("jnz_taken", 32'(imem_addr), 32'h10);
    cyc(); cyc(); cyc();
    check("jmp_ff", 32'(imem_addr), 32'hFF);
    cyc(); cyc(); cyc();
    check("wrap_addr", 32'(imem_addr), 0);
    check("wrap_req", 32'(imem_req), 1);

    // HALT
    cyc();
    check("halt_iv", 32'(issue_valid), 1);
    cyc();
    check("halted", 32'(halted), 1);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (imem_req || !halted) cnt++;
      cyc();
    end
    check("halt_quiet", 32'(cnt), 0);
    check("halt_hold", 32'({c_addr, a_addr, b_addr, immediate_val}), 32'h123_45);
    RST = 1'b1;
    cyc();
    check("halt_rst_pc", 32'(pc), 0);
    check("halt_rst_flags", 32'({halted, imem_req}), 0);
    RST = 1'b0;
    mem[8'h00] = 24'h900020;  // ST
    exec_busy = 1'b1;
    cyc();
    check("restart_req", 32'({imem_req, imem_addr}), 32'h100);

    // Reset during an EXEC stall, then reset coincident with ack
    cyc();
    check("st_ctrl", 32'({data_write, data_read, reg_write}), 32'b100);
    cyc(); cyc();
    check("st_stalled", 32'(imem_req), 0);
    RST = 1'b1;
    cyc();
    check("midrst_state", 32'({imem_req, issue_valid, halted, data_write}), 0);
    check("midrst_pc", 32'(pc), 0);
    RST = 1'b0; exec_busy = 1'b0;
    mem[8'h00] = 24'h1A2355;
    cyc();
    check("ackrst_fetch", 32'(imem_req), 1);
    RST = 1'b1;
    cyc();
    check("ackrst_iv", 32'(issue_valid), 0);
    check("ackrst_fields", 32'({reg_write, c_addr}), 0);
    RST = 1'b0;
    cyc();
    check("ackrst_idle_iv", 32'({issue_valid, imem_req}), 32'b01);
    cyc();
    check("ackrst_next_iv", 32'({issue_valid, c_addr}), 32'h1A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Upstream front end of the single-cycle-issue CPU: it owns the program counter, fetches 24-bit instruction words from instruction memory over a req/ack handshake, and decodes each word into the register-address, immediate, ALU, jump and memory control fields. These fields feed the instruction register stage, which captures them on the falling clock edge. The block then resolves JCTL branches using the ALU zero flag to select the next PC.

## Interface
- PC_WIDTH, 8, program counter and instruction-memory address width; jump targets are the low PC_WIDTH bits of the 8-bit addr field.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- imem_addr  out  PC_WIDTH  fetch address, equal to pc.
- imem_req  out  1  fetch request; high exactly while state = FETCH.
- imem_ack  in  1  instruction memory has valid imem_data this cycle; ignored outside FETCH.
- imem_data  in  24  instruction word: [23:20] opcode, [19:16] c_addr, [15:12] a_addr, [11:8] b_addr, [7:0] imm/addr.
- exec_busy  in  1  downstream (data memory) stall; ignored outside EXEC.
- alu_zero  in  1  ALU result-is-zero flag; sampled in the EXEC cycle where exec_busy = 0.
- a_addr, b_addr, c_addr  out  4 each  register addresses; c = a op b.
- immediate_val  out  8  copy of word[7:0].
- addr  out  8  copy of word[7:0]; data address or jump target.
- alu_control  out  3  ALU operation.
- JCTL  out  2  jump control: 00 none, 01 always, 10 if zero, 11 if not zero.
- im_sel, reg_write, data_read, data_write, reg_addr  out  1 each  immediate select, register write-enable, data-memory read, data-memory write, memory address from register (1) or from addr (0).
- issue_valid  out  1  high during the DECODE cycle only; the fields are new this cycle.
- halted  out  1  high while state = HALT.
- pc  out  PC_WIDTH  current program counter.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- Reset value of the state is IDLE.
- On reset, pc = 0 and every decoded output, issue_valid and halted are 0.
- IDLE -> FETCH unconditionally after one cycle.
- FETCH: imem_req = 1 and imem_addr = pc. On imem_ack = 1, decode imem_data into the output registers on that edge and go to DECODE. Otherwise remain in FETCH indefinitely.
- DECODE: issue_valid = 1. Always go to EXEC. If the opcode is HALT, go to HALT instead.
- EXEC: hold all outputs. When exec_busy = 0, update pc and go to FETCH. While exec_busy = 1, pc and outputs stay frozen.
- Next-PC rule when leaving EXEC:
  - JCTL 01: pc = addr.
  - JCTL 10: pc = addr if alu_zero = 1, else pc+1.
  - JCTL 11: pc = addr if alu_zero = 0, else pc+1.
  - JCTL 00: pc = pc+1.
  - pc+1 wraps modulo 2^PC_WIDTH, so the word after all-ones is 0.
- HALT: terminal state. Outputs hold their last decode, halted = 1, imem_req = 0. Only RST exits this state.
- Decode rules:
  - a/b/c_addr, immediate_val and addr always pass through from the word.
  - Every control bit not listed for an opcode is 0.
- Opcode map:
  - 0 NOP.
  - 1 ADD: alu 000, reg_write.
  - 2 SUB: alu 001, reg_write.
  - 3 AND: alu 010, reg_write.
  - 4 OR: alu 011, reg_write.
  - 5 XOR: alu 100, reg_write.
  - 6 ADDI: alu 000, im_sel, reg_write.
  - 7 LDI: alu 101 (pass B), im_sel, reg_write.
  - 8 LD: data_read, reg_write.
  - 9 ST: data_write.
  - A LDR: data_read, reg_write, reg_addr.
  - B STR: data_write, reg_addr.
  - C JMP: JCTL 01.
  - D JZ: JCTL 10.
  - E JNZ: JCTL 11.
  - F HALT: all control 0.
- Simultaneous events:
  - imem_ack in the same cycle as RST: reset wins and no decode occurs.
  - RST in any state, including mid-EXEC stall or HALT: next state is IDLE and pc = 0.

## Timing
- Minimum 3 cycles per instruction: FETCH 1 (ack in the request cycle) + DECODE 1 + EXEC 1. Each imem_ack wait cycle or exec_busy cycle adds 1 cycle.
- First imem_req after RST deasserts: 2 cycles later (IDLE, then FETCH).
- Decoded fields stay stable from the DECODE cycle through the end of EXEC. The falling edge inside the DECODE cycle is therefore a safe capture point for the instruction register.
- A pc change becomes visible on imem_addr in the following FETCH cycle.
- There is no prefetch: only one instruction is in flight at a time.

## Test plan
- Reset and first fetch:
  - Stimulus: hold RST 2 cycles, imem_ack tied 1.
  - Response: outputs all 0 during reset; imem_req rises in cycle 2 after release with imem_addr = 0; issue_valid pulses every 3 cycles.
- ALU decode and ack stall:
  - Stimulus: word 0x1A23xx delivered with imem_ack delayed 3 cycles.
  - Response: imem_req is held for 4 cycles; then c_addr = A, a_addr = 2, b_addr = 3, alu_control = 000, reg_write = 1, other controls 0.
- Memory stall:
  - Stimulus: LDR 0xA1200x with exec_busy high 4 cycles.
  - Response: data_read = reg_write = reg_addr = 1; pc holds until busy drops, then pc increments by 1.
- Branches:
  - Stimulus: JZ target 0x40 with alu_zero = 1.
  - Response: next imem_addr = 0x40.
  - Stimulus: the same JZ with alu_zero = 0.
  - Response: next imem_addr = pc+1.
  - Stimulus: JNZ target 0x10 with alu_zero = 0.
  - Response: next imem_addr = 0x10.
- Wrap and halt:
  - Stimulus: NOP at pc = 0xFF.
  - Response: next fetch is at 0x00.
  - Stimulus: HALT word.
  - Response: halted = 1 and imem_req stays 0 for 20 cycles; RST returns pc = 0 and fetching restarts.
- Reset mid-operation:
  - Stimulus: assert RST during an EXEC stall, with imem_ack coincident with RST on a later fetch.
  - Response: next state is IDLE; no issue_valid pulse is produced for the acked word.
